// File: rtl/dclock_pkg.sv
// Shared limits and time-of-day record for the dclock_rtc slice.
package dclock_pkg;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HRS_MAX = 23;
  localparam int HRS_W   = 5;

  typedef struct packed {
    logic [HRS_W-1:0] hrs;
    logic [5:0]       min;
    logic [5:0]       sec;
  } time_t;
endpackage

// File: rtl/dclock_prescaler.sv
// Divides clk down to a one-cycle sec_tick every CLK_DIV running cycles.
module dclock_prescaler #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic sec_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count holds while run is low, so a paused second resumes where it stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (run)      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign sec_tick = run && (cnt == LAST);
endmodule

// File: rtl/dclock_rtc.sv
// hh:mm:ss real-time clock with load, 12/24h view and day pulse.
// Optional hh:mm alarm enabled by defining DCLOCK_ALARM_EN.
module dclock_rtc
  import dclock_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int W       = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         mode_12h,
  input  logic         load,
  input  logic [W-1:0] set_hrs,
  input  logic [W-1:0] set_min,
  input  logic [W-1:0] set_sec,
  input  logic         alm_wr,
  input  logic [W-1:0] alm_hrs,
  input  logic [W-1:0] alm_min,
  input  logic         alm_on,
  input  logic         alm_ack,
  output logic [W-1:0] hrs,
  output logic [W-1:0] min,
  output logic [W-1:0] sec,
  output logic         pm,
  output logic         day_tick,
  output logic         set_err,
  output logic         alarm_hit
);
  time_t            t, nxt;
  logic             tick, load_ok, load_bad, alm_bad, wrap;
  logic [HRS_W-1:0] h_disp;

  assign load_ok  = load && (set_hrs <= W'(HRS_MAX)) && (set_min <= W'(MIN_MAX))
                         && (set_sec <= W'(SEC_MAX));
  assign load_bad = load && !load_ok;

  dclock_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clear    (load_ok),
    .sec_tick (tick)
  );

  // An accepted load swallows a coincident tick.
  always_comb begin
    nxt  = t;
    wrap = 1'b0;
    if (load_ok) begin
      nxt = '{hrs: set_hrs[HRS_W-1:0], min: set_min[5:0], sec: set_sec[5:0]};
    end else if (tick) begin
      if (t.sec == 6'(SEC_MAX)) begin
        nxt.sec = '0;
        if (t.min == 6'(MIN_MAX)) begin
          nxt.min = '0;
          if (t.hrs == HRS_W'(HRS_MAX)) begin
            nxt.hrs = '0;
            wrap    = 1'b1;
          end else begin
            nxt.hrs = t.hrs + HRS_W'(1);
          end
        end else begin
          nxt.min = t.min + 6'd1;
        end
      end else begin
        nxt.sec = t.sec + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t        <= '0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      t        <= nxt;
      day_tick <= wrap;
      set_err  <= load_bad || alm_bad;
    end
  end

`ifdef DCLOCK_ALARM_EN
  logic [HRS_W-1:0] alm_h;
  logic [5:0]       alm_m;
  logic             alm_ok, alm_match, hit;

  assign alm_ok    = (alm_hrs <= W'(HRS_MAX)) && (alm_min <= W'(MIN_MAX));
  assign alm_bad   = alm_wr && !alm_ok;
  assign alm_match = (load_ok || tick) && alm_on && (nxt.hrs == alm_h)
                     && (nxt.min == alm_m) && (nxt.sec == 6'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alm_h <= '0;
      alm_m <= '0;
      hit   <= 1'b0;
    end else begin
      if (alm_wr && alm_ok) begin
        alm_h <= alm_hrs[HRS_W-1:0];
        alm_m <= alm_min[5:0];
      end
      if (alm_match)                hit <= 1'b1;
      else if (alm_ack || !alm_on)  hit <= 1'b0;
    end
  end

  assign alarm_hit = hit;
`else
  logic unused_alm;
  assign unused_alm = ^{alm_wr, alm_hrs, alm_min, alm_on, alm_ack};
  assign alm_bad    = 1'b0;
  assign alarm_hit  = 1'b0;
`endif

  // Presentation only; internal hour stays 0..23.
  always_comb begin
    if (t.hrs == '0)                       h_disp = HRS_W'(12);
    else if (!mode_12h || t.hrs <= HRS_W'(12)) h_disp = t.hrs;
    else                                   h_disp = t.hrs - HRS_W'(12);
  end

  assign hrs = {{(W-HRS_W){1'b0}}, (mode_12h ? h_disp : t.hrs)};
  assign min = {{(W-6){1'b0}}, t.min};
  assign sec = {{(W-6){1'b0}}, t.sec};
  assign pm  = (t.hrs >= HRS_W'(12));
endmodule

// File: tb/tb_dclock_rtc.sv
// Self-checking bench for dclock_rtc: vector table + scoreboard queue, plus reset and prescaler sequences.
module tb_dclock_rtc;
  localparam int W = 7;
`ifdef DCLOCK_ALARM_EN
  localparam bit A = 1'b1;
`else
  localparam bit A = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, run, mode_12h, load, alm_wr, alm_on, alm_ack;
  logic [W-1:0] set_hrs, set_min, set_sec, alm_hrs, alm_min;
  logic [W-1:0] hrs, min, sec;
  logic pm, day_tick, set_err, alarm_hit;

  logic run4, zb;
  logic [W-1:0] zw;
  logic [W-1:0] hrs4, min4, sec4;
  logic pm4, day4, err4, alm4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dclock_rtc #(.CLK_DIV(1), .W(W)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h), .load(load),
    .set_hrs(set_hrs), .set_min(set_min), .set_sec(set_sec),
    .alm_wr(alm_wr), .alm_hrs(alm_hrs), .alm_min(alm_min), .alm_on(alm_on), .alm_ack(alm_ack),
    .hrs(hrs), .min(min), .sec(sec), .pm(pm), .day_tick(day_tick),
    .set_err(set_err), .alarm_hit(alarm_hit)
  );

  dclock_rtc #(.CLK_DIV(4), .W(W)) dut4 (
    .clk(clk), .rst(rst), .run(run4), .mode_12h(zb), .load(zb),
    .set_hrs(zw), .set_min(zw), .set_sec(zw),
    .alm_wr(zb), .alm_hrs(zw), .alm_min(zw), .alm_on(zb), .alm_ack(zb),
    .hrs(hrs4), .min(min4), .sec(sec4), .pm(pm4), .day_tick(day4),
    .set_err(err4), .alarm_hit(alm4)
  );

  typedef struct {
    bit run, mode, load, awr, aon, ack;
    int sh, sm, ss, ah, am;
    int eh, em, es;
    bit epm, eday, eerr, ealm;
  } vec_t;

  typedef struct {
    int h, m, s;
    bit pm, day, err, alm;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[29];

  task automatic cmp(input string nm, input int idx, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    run = v.run; mode_12h = v.mode; load = v.load;
    alm_wr = v.awr; alm_on = v.aon; alm_ack = v.ack;
    set_hrs = W'(v.sh); set_min = W'(v.sm); set_sec = W'(v.ss);
    alm_hrs = W'(v.ah); alm_min = W'(v.am);
    e = '{h: v.eh, m: v.em, s: v.es, pm: v.epm, day: v.eday, err: v.eerr, alm: v.ealm};
    exp_q.push_back(e);
  endtask

  task automatic check_out(input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      cmp("queue_empty", idx, 1, 0);
    end else begin
      e = exp_q.pop_front();
      cmp("hrs", idx, int'(hrs), e.h);
      cmp("min", idx, int'(min), e.m);
      cmp("sec", idx, int'(sec), e.s);
      cmp("pm", idx, int'(pm), int'(e.pm));
      cmp("day_tick", idx, int'(day_tick), int'(e.day));
      cmp("set_err", idx, int'(set_err), int'(e.err));
      cmp("alarm_hit", idx, int'(alarm_hit), int'(e.alm));
    end
  endtask

  initial begin
    vec_t v;
    int c4, s4;
    bit r4 [14];

    //        run mode load awr aon ack  sh sm ss  ah am  eh em es  pm day err alm
    tbl[0]  = '{0,0,1,0,0,0, 23,59,58, 0,0, 23,59,58, 1,0,0,0};
    tbl[1]  = '{1,0,0,0,0,0,  0, 0, 0, 0,0, 23,59,59, 1,0,0,0};
    tbl[2]  = '{1,0,0,0,0,0,  0, 0, 0, 0,0,  0, 0, 0, 0,1,0,0};
    tbl[3]  = '{1,0,0,0,0,0,  0, 0, 0, 0,0,  0, 0, 1, 0,0,0,0};
    tbl[4]  = '{0,0,1,0,0,0, 25, 0, 0, 0,0,  0, 0, 1, 0,0,1,0};
    tbl[5]  = '{0,0,0,0,0,0,  0, 0, 0, 0,0,  0, 0, 1, 0,0,0,0};
    tbl[6]  = '{1,0,1,0,0,0, 10,20,30, 0,0, 10,20,30, 0,0,0,0};
    tbl[7]  = '{1,0,0,0,0,0,  0, 0, 0, 0,0, 10,20,31, 0,0,0,0};
    tbl[8]  = '{0,0,1,0,0,0,  5,59,60, 0,0, 10,20,31, 0,0,1,0};
    tbl[9]  = '{0,0,1,0,0,0,  0,59,59, 0,0,  0,59,59, 0,0,0,0};
    tbl[10] = '{1,0,0,0,0,0,  0, 0, 0, 0,0,  1, 0, 0, 0,0,0,0};
    tbl[11] = '{0,1,1,0,0,0,  0,30, 0, 0,0, 12,30, 0, 0,0,0,0};
    tbl[12] = '{0,1,1,0,0,0, 13, 5, 0, 0,0,  1, 5, 0, 1,0,0,0};
    tbl[13] = '{0,0,0,0,0,0,  0, 0, 0, 0,0, 13, 5, 0, 1,0,0,0};
    tbl[14] = '{0,1,1,0,0,0, 11,59,59, 0,0, 11,59,59, 0,0,0,0};
    tbl[15] = '{1,1,0,0,0,0,  0, 0, 0, 0,0, 12, 0, 0, 1,0,0,0};
    tbl[16] = '{0,0,0,1,1,0,  0, 0, 0, 7,0, 12, 0, 0, 1,0,0,0};
    tbl[17] = '{0,0,1,0,1,0,  6,59,58, 0,0,  6,59,58, 0,0,0,0};
    tbl[18] = '{1,0,0,0,1,0,  0, 0, 0, 0,0,  6,59,59, 0,0,0,0};
    tbl[19] = '{1,0,0,0,1,0,  0, 0, 0, 0,0,  7, 0, 0, 0,0,0,A};
    tbl[20] = '{1,0,0,0,1,0,  0, 0, 0, 0,0,  7, 0, 1, 0,0,0,A};
    tbl[21] = '{0,0,0,0,1,1,  0, 0, 0, 0,0,  7, 0, 1, 0,0,0,0};
    tbl[22] = '{0,0,0,0,1,0,  0, 0, 0, 0,0,  7, 0, 1, 0,0,0,0};
    tbl[23] = '{0,0,1,0,1,0,  7, 0, 0, 0,0,  7, 0, 0, 0,0,0,A};
    tbl[24] = '{0,0,1,0,1,1,  7, 0, 0, 0,0,  7, 0, 0, 0,0,0,A};
    tbl[25] = '{0,0,0,0,0,0,  0, 0, 0, 0,0,  7, 0, 0, 0,0,0,0};
    tbl[26] = '{0,0,0,1,0,0,  0, 0, 0,24,0,  7, 0, 0, 0,0,A,0};
    tbl[27] = '{0,0,1,1,0,0, 25, 0, 0,24,0,  7, 0, 0, 0,0,1,0};
    tbl[28] = '{0,0,0,0,0,0,  0, 0, 0, 0,0,  7, 0, 0, 0,0,0,0};

    rst = 1'b0; run = 0; mode_12h = 0; load = 0; alm_wr = 0; alm_on = 0; alm_ack = 0;
    set_hrs = '0; set_min = '0; set_sec = '0; alm_hrs = '0; alm_min = '0;
    run4 = 0; zb = 0; zw = '0;

    // Reset state, including the mode-dependent hour view
    #2;
    cmp("rst_hrs", 0, int'(hrs), 0);
    cmp("rst_sec", 0, int'(sec), 0);
    cmp("rst_flags", 0, int'({pm, day_tick, set_err, alarm_hit}), 0);
    mode_12h = 1;
    #1;
    cmp("rst_hrs12", 0, int'(hrs), 12);
    mode_12h = 0;
    #10 rst = 1'b1;

    // Count to 00:00:37, then reset mid-count
    run = 1;
    for (int i = 1; i <= 37; i++) begin
      v = '{1,0,0,0,0,0, 0,0,0,0,0, 0,0,i, 0,0,0,0};
      drive(v);
      check_out(100 + i);
    end
    #3 rst = 1'b0;
    #1;
    cmp("async_rst_sec", 0, int'(sec), 0);
    cmp("async_rst_min", 0, int'(min), 0);
    #2 rst = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      v = '{1,0,0,0,0,0, 0,0,0,0,0, 0,0,i, 0,0,0,0};
      drive(v);
      check_out(200 + i);
    end

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i]);
      check_out(i);
    end
    run = 0; load = 0; alm_wr = 0; alm_ack = 0; alm_on = 0;

    // CLK_DIV=4 instance: run pattern with a pause mid-second
    r4 = '{1,1,1,1,1,1,0,0,0,1,1,1,1,1};
    c4 = 0; s4 = 0;
    for (int i = 0; i < 14; i++) begin
      run4 = r4[i];
      if (r4[i]) begin
        if (c4 == 3) begin c4 = 0; s4++; end
        else c4++;
      end
      @(posedge clk);
      #1;
      cmp("div4_sec", 300 + i, int'(sec4), s4);
    end
    run4 = 0;
    cmp("div4_day", 0, int'(day4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
